reg_share_arbiter: RTL and testbench
====================================

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- XW, 3, width of x register and x data ports
- YW, 8, width of y register and y data ports
- MAX_HOLD, 4, maximum consecutive writes per grant; legal range 1..15
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge
- rst_n, in, 1, reset, asynchronous assert, active-low
- x_init, in, XW, value loaded into x register on every init sequence
- y_init, in, YW, value loaded into y register on every init sequence
- init_req, in, 1, request to reload the init values; level-sensitive
- a_req, in, 1, requester A wants to write
- a_x / a_y, in, XW / YW, requester A write data
- b_req, in, 1, requester B wants to write
- b_x / b_y, in, XW / YW, requester B write data
- a_gnt / b_gnt, out, 1, requester currently owns the registers
- x_out / y_out, out, XW / YW, current x / y register contents
- init_done, out, 1, one-cycle pulse after the init values are loaded

Function
REQ-003 SHALL implement the states INIT, IDLE, OWN_A and OWN_B.
REQ-004 SHALL drive a_gnt = (state==OWN_A) and b_gnt = (state==OWN_B), and SHALL never assert both.
REQ-005 SHALL drive x_out and y_out directly from the x and y registers, with no combinational path from the inputs.
REQ-006 In INIT, at the next edge: x <= x_init, y <= y_init, init_done <= 1, and the state goes to IDLE.
REQ-007 init_done SHALL be high for exactly the one cycle following each INIT cycle.
REQ-008 In IDLE, on each edge, the first matching rule in this order SHALL apply:
- init_req -> INIT
- a_req and b_req both high -> the owner is the requester not equal to last
- only one request high -> that requester's OWN state
- no request -> stay in IDLE
REQ-009 On entering an OWN state, hold_cnt SHALL be cleared to 0.
REQ-010 A grant SHALL become visible one cycle after the request is sampled.
REQ-011 No write SHALL occur in IDLE.
REQ-012 In OWN_A, on each edge, the first matching rule in this order SHALL apply; OWN_B is symmetric:
- init_req -> INIT, no write
- !a_req -> release, no write
- otherwise write x <= a_x, y <= a_y and increment hold_cnt; if hold_cnt was MAX_HOLD-1, release after the write
REQ-013 On release from OWN_A: last <= A; the next state is OWN_B if b_req is high, else IDLE.
REQ-014 A direct OWN_A -> OWN_B handoff SHALL clear hold_cnt and SHALL give B's first write on the cycle after the handoff.
REQ-015 A requester that keeps a_req high with no competitor SHALL be re-granted via IDLE, giving one dead cycle between bursts.
REQ-016 hold_cnt SHALL be wide enough for MAX_HOLD and SHALL never wrap.
REQ-017 Data ports of a non-granted requester SHALL be ignored.
REQ-018 Changes on x_init / y_init outside INIT SHALL have no effect.

Reset
REQ-019 While rst_n is low, the block SHALL asynchronously hold: state=INIT, x_out=0, y_out=0, a_gnt=0, b_gnt=0, init_done=0, hold_cnt=0, last=B.
REQ-020 The first edge after rst_n rises SHALL perform the INIT load of REQ-006.
REQ-021 Reset asserted mid-burst SHALL immediately drop the grant and zero the registers; no partial write SHALL survive.

Verification
REQ-022 Reset, then release with x_init=5, y_init=8'hA5 -> x_out=0, y_out=0 during reset; x_out=5, y_out=8'hA5 and init_done=1 one cycle after release; init_done=0 on the next cycle.
REQ-023 Hold a_req=1 only, with a_x incrementing 1,2,3,... and MAX_HOLD=4 -> a_gnt high for 4 cycles, x_out takes 1..4 in consecutive cycles, one IDLE cycle, then a_gnt reasserts.
REQ-024 Raise a_req and b_req in the same IDLE cycle after reset -> A is granted first (last=B); after A's 4 writes, b_gnt rises with no IDLE gap; next contention goes to A.
REQ-025 During OWN_B with b_y=8'h3C, pulse init_req for 1 cycle with y_init=8'h11 -> no write that cycle; b_gnt falls; y_out=8'h11 and init_done=1 next cycle; state returns to IDLE.
REQ-026 Assert rst_n=0 asynchronously mid-burst between clock edges -> a_gnt, b_gnt, x_out and y_out read 0 before the next edge.
REQ-027 Drop a_req after 2 writes while b_req is low -> a_gnt falls next cycle, x_out holds the second value, state goes to IDLE.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// reg_share_arbiter
//
// Two requesters (A and B) share one pair of registers, x and y. A small FSM
// decides who owns the pair. Only the owner's data is written, one word per
// cycle. A burst ends when the owner drops its request or after MAX_HOLD
// writes. On contention the requester that did not own the pair last time
// wins. An init sequence reloads x/y from x_init/y_init and pulses init_done.
//
// Parameters
//   XW        width of the x register and x data ports
//   YW        width of the y register and y data ports
//   MAX_HOLD  maximum consecutive writes per grant (legal range 1..15)
//
// Ports
//   clk        single clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   x_init     value loaded into x on every init sequence
//   y_init     value loaded into y on every init sequence
//   init_req   level-sensitive request to reload the init values
//   a_req      requester A wants to write
//   a_x, a_y   requester A write data
//   b_req      requester B wants to write
//   b_x, b_y   requester B write data
//   a_gnt      requester A owns the registers (registered)
//   b_gnt      requester B owns the registers (registered)
//   x_out      current x register contents
//   y_out      current y register contents
//   init_done  one-cycle pulse after the init values are loaded
// -----------------------------------------------------------------------------
module reg_share_arbiter #(
  parameter int XW       = 3,
  parameter int YW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] x_init,
  input  logic [YW-1:0] y_init,
  input  logic          init_req,
  input  logic          a_req,
  input  logic [XW-1:0] a_x,
  input  logic [YW-1:0] a_y,
  input  logic          b_req,
  input  logic [XW-1:0] b_x,
  input  logic [YW-1:0] b_y,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          init_done
);

  // hold_cnt must be able to represent MAX_HOLD itself: after the last write
  // of a full burst it holds MAX_HOLD until the next grant clears it.
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  // Identity of the previous owner, used for alternating on contention.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_OWN_A = 2'd2,
    S_OWN_B = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic            last_q, last_d;
  logic            init_done_q, init_done_d;
  logic            a_gnt_q, a_gnt_d;
  logic            b_gnt_q, b_gnt_d;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    init_done_d = 1'b0;

    unique case (state_q)
      S_INIT: begin
        x_d         = x_init;
        y_d         = y_init;
        init_done_d = 1'b1;
        state_d     = S_IDLE;
      end

      S_IDLE: begin
        if (init_req) begin
          state_d = S_INIT;
        end else if (a_req && b_req) begin
          state_d = (last_q == OWNER_B) ? S_OWN_A : S_OWN_B;
        end else if (a_req) begin
          state_d = S_OWN_A;
        end else if (b_req) begin
          state_d = S_OWN_B;
        end
      end

      S_OWN_A: begin
        if (init_req) begin
          state_d = S_INIT;
        end else if (!a_req) begin
          last_d  = OWNER_A;
          state_d = b_req ? S_OWN_B : S_IDLE;
        end else begin
          x_d        = a_x;
          y_d        = a_y;
          hold_cnt_d = hold_cnt_q + HCW'(1);
          // Burst limit reached: release right after this write.
          if (hold_cnt_q == HOLD_LAST) begin
            last_d  = OWNER_A;
            state_d = b_req ? S_OWN_B : S_IDLE;
          end
        end
      end

      S_OWN_B: begin
        if (init_req) begin
          state_d = S_INIT;
        end else if (!b_req) begin
          last_d  = OWNER_B;
          state_d = a_req ? S_OWN_A : S_IDLE;
        end else begin
          x_d        = b_x;
          y_d        = b_y;
          hold_cnt_d = hold_cnt_q + HCW'(1);
          if (hold_cnt_q == HOLD_LAST) begin
            last_d  = OWNER_B;
            state_d = a_req ? S_OWN_A : S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // Any entry into an ownership state, including a direct A<->B handoff,
    // starts a fresh burst count.
    if ((state_d == S_OWN_A || state_d == S_OWN_B) && (state_d != state_q)) begin
      hold_cnt_d = '0;
    end

    // Grants are registered copies of the next state, so they track state_q.
    a_gnt_d = (state_d == S_OWN_A);
    b_gnt_d = (state_d == S_OWN_B);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      x_q         <= '0;
      y_q         <= '0;
      hold_cnt_q  <= '0;
      last_q      <= OWNER_B;
      init_done_q <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      init_done_q <= init_done_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
module tb_reg_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] x_init;
  logic [7:0] y_init;
  logic       init_req;
  logic       a_req;
  logic [2:0] a_x;
  logic [7:0] a_y;
  logic       b_req;
  logic [2:0] b_x;
  logic [7:0] b_y;
  logic       a_gnt;
  logic       b_gnt;
  logic [2:0] x_out;
  logic [7:0] y_out;
  logic       init_done;

  int n_tests;
  int n_fail;

  reg_share_arbiter #(.XW(3), .YW(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_init    (x_init),
    .y_init    (y_init),
    .init_req  (init_req),
    .a_req     (a_req),
    .a_x       (a_x),
    .a_y       (a_y),
    .b_req     (b_req),
    .b_x       (b_x),
    .b_y       (b_y),
    .a_gnt     (a_gnt),
    .b_gnt     (b_gnt),
    .x_out     (x_out),
    .y_out     (y_out),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ir;
    logic [2:0] xi;
    logic [7:0] yi;
    logic       ar;
    logic [2:0] ax;
    logic [7:0] ay;
    logic       br;
    logic [2:0] bx;
    logic [7:0] by;
    logic       e_ag;
    logic       e_bg;
    logic [2:0] e_x;
    logic [7:0] e_y;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input logic [2:0] xi, input logic [7:0] yi,
    input logic ar, input logic [2:0] ax, input logic [7:0] ay,
    input logic br, input logic [2:0] bx, input logic [7:0] by,
    input logic e_ag, input logic e_bg, input logic [2:0] e_x,
    input logic [7:0] e_y, input logic e_done);
    vec_t v;
    v.ir = ir; v.xi = xi; v.yi = yi;
    v.ar = ar; v.ax = ax; v.ay = ay;
    v.br = br; v.bx = bx; v.by = by;
    v.e_ag = e_ag; v.e_bg = e_bg; v.e_x = e_x; v.e_y = e_y; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eag, input logic ebg,
                         input logic [2:0] ex, input logic [7:0] ey, input logic ed);
    chk({tag, " a_gnt"},     32'(a_gnt),     32'(eag));
    chk({tag, " b_gnt"},     32'(b_gnt),     32'(ebg));
    chk({tag, " x_out"},     32'(x_out),     32'(ex));
    chk({tag, " y_out"},     32'(y_out),     32'(ey));
    chk({tag, " init_done"}, 32'(init_done), 32'(ed));
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    x_init   = 3'd5;
    y_init   = 8'hA5;
    init_req = 1'b0;
    a_req = 1'b0; a_x = 3'd7; a_y = 8'hEE;
    b_req = 1'b0; b_x = 3'd6; b_y = 8'hFF;

    //        ir xi    yi     ar ax    ay     br bx    by     ag bg x     y      done
    vecs.push_back(mk(0, 3'd5, 8'hA5, 0, 3'd7, 8'hEE, 0, 3'd6, 8'hFF, 0, 0, 3'd5, 8'hA5, 1)); // r0 init load
    vecs.push_back(mk(0, 3'd2, 8'h00, 0, 3'd7, 8'hEE, 0, 3'd6, 8'hFF, 0, 0, 3'd5, 8'hA5, 0)); // r1 init vals ignored
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd7, 8'hEE, 0, 3'd6, 8'hFF, 1, 0, 3'd5, 8'hA5, 0)); // r2 grant, no write
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd1, 8'h01, 0, 3'd6, 8'hFF, 1, 0, 3'd1, 8'h01, 0)); // r3 write 1
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd2, 8'h02, 0, 3'd6, 8'hFF, 1, 0, 3'd2, 8'h02, 0)); // r4 write 2
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd3, 8'h03, 0, 3'd6, 8'hFF, 1, 0, 3'd3, 8'h03, 0)); // r5 write 3
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd4, 8'h04, 0, 3'd6, 8'hFF, 0, 0, 3'd4, 8'h04, 0)); // r6 write 4, release
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd5, 8'h05, 0, 3'd6, 8'hFF, 1, 0, 3'd4, 8'h04, 0)); // r7 regrant after dead cycle
    vecs.push_back(mk(0, 3'd2, 8'h00, 0, 3'd5, 8'h05, 0, 3'd6, 8'hFF, 0, 0, 3'd4, 8'h04, 0)); // r8 drop, no write
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd1, 8'h10, 1, 3'd6, 8'h60, 0, 1, 3'd4, 8'h04, 0)); // r9 contention -> B (last=A)
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd1, 8'h10, 1, 3'd6, 8'h60, 0, 1, 3'd6, 8'h60, 0)); // r10 B writes
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd1, 8'h10, 0, 3'd6, 8'h60, 1, 0, 3'd6, 8'h60, 0)); // r11 B drops, handoff to A
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd3, 8'h33, 0, 3'd6, 8'h60, 1, 0, 3'd3, 8'h33, 0)); // r12 A write 1
    vecs.push_back(mk(0, 3'd2, 8'h00, 1, 3'd2, 8'h22, 1, 3'd7, 8'h70, 1, 0, 3'd2, 8'h22, 0)); // r13 A write 2
    vecs.push_back(mk(0, 3'd2, 8'h00, 0, 3'd2, 8'h22, 1, 3'd7, 8'h70, 0, 1, 3'd2, 8'h22, 0)); // r14 A drops, handoff to B
    vecs.push_back(mk(1, 3'd6, 8'h11, 0, 3'd2, 8'h22, 1, 3'd1, 8'h3C, 0, 0, 3'd2, 8'h22, 0)); // r15 init_req in OWN_B
    vecs.push_back(mk(0, 3'd6, 8'h11, 0, 3'd2, 8'h22, 1, 3'd1, 8'h3C, 0, 0, 3'd6, 8'h11, 1)); // r16 init load
    vecs.push_back(mk(0, 3'd6, 8'h11, 0, 3'd2, 8'h22, 1, 3'd1, 8'h3C, 0, 1, 3'd6, 8'h11, 0)); // r17 B grant from IDLE
    vecs.push_back(mk(0, 3'd6, 8'h11, 0, 3'd2, 8'h22, 1, 3'd5, 8'h3C, 0, 1, 3'd5, 8'h3C, 0)); // r18 B write
    vecs.push_back(mk(0, 3'd6, 8'h11, 0, 3'd2, 8'h22, 0, 3'd5, 8'h3C, 0, 0, 3'd5, 8'h3C, 0)); // r19 B release
    vecs.push_back(mk(1, 3'd1, 8'h77, 0, 3'd2, 8'h22, 0, 3'd5, 8'h3C, 0, 0, 3'd5, 8'h3C, 0)); // r20 IDLE -> INIT
    vecs.push_back(mk(1, 3'd1, 8'h77, 0, 3'd2, 8'h22, 0, 3'd5, 8'h3C, 0, 0, 3'd1, 8'h77, 1)); // r21 load
    vecs.push_back(mk(1, 3'd1, 8'h77, 0, 3'd2, 8'h22, 0, 3'd5, 8'h3C, 0, 0, 3'd1, 8'h77, 0)); // r22 level init_req again
    vecs.push_back(mk(0, 3'd3, 8'h99, 0, 3'd2, 8'h22, 0, 3'd5, 8'h3C, 0, 0, 3'd3, 8'h99, 1)); // r23 second load
    vecs.push_back(mk(0, 3'd3, 8'h99, 0, 3'd2, 8'h22, 0, 3'd5, 8'h3C, 0, 0, 3'd3, 8'h99, 0)); // r24 pulse ends

    // Reset state, including across clock edges while held.
    #2;
    chk_all("reset t2", 0, 0, 3'd0, 8'h00, 0);
    step();
    step();
    chk_all("reset held", 0, 0, 3'd0, 8'h00, 0);

    // Release between edges so the next edge performs the INIT load.
    #3;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      init_req = vecs[i].ir;
      x_init   = vecs[i].xi;
      y_init   = vecs[i].yi;
      a_req    = vecs[i].ar;
      a_x      = vecs[i].ax;
      a_y      = vecs[i].ay;
      b_req    = vecs[i].br;
      b_x      = vecs[i].bx;
      b_y      = vecs[i].by;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].e_ag, vecs[i].e_bg,
              vecs[i].e_x, vecs[i].e_y, vecs[i].e_done);
    end

    // Asynchronous reset in the middle of an A burst.
    init_req = 1'b0; b_req = 1'b0;
    a_req = 1'b1; a_x = 3'd2; a_y = 8'h42;
    step();
    chk_all("mid grant", 1, 0, 3'd3, 8'h99, 0);
    step();
    chk_all("mid write", 1, 0, 3'd2, 8'h42, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async rst", 0, 0, 3'd0, 8'h00, 0);
    step();
    chk_all("async rst held", 0, 0, 3'd0, 8'h00, 0);

    // After reset last=B, so simultaneous requests go to A first,
    // then hand off to B with no gap, then back to A.
    x_init = 3'd5; y_init = 8'hA5;
    a_req = 1'b1; b_req = 1'b1;
    a_x = 3'd0; a_y = 8'h00; b_x = 3'd0; b_y = 8'h00;
    #3;
    rst_n = 1'b1;
    step();
    chk_all("post rst init", 0, 0, 3'd5, 8'hA5, 1);
    step();
    chk_all("cont grant A", 1, 0, 3'd5, 8'hA5, 0);
    for (int k = 1; k <= 4; k++) begin
      a_x = 3'(k);
      a_y = 8'hA0 + 8'(k);
      step();
      chk_all($sformatf("cont A w%0d", k), (k < 4), (k == 4), 3'(k), 8'hA0 + 8'(k), 0);
    end
    for (int k = 1; k <= 4; k++) begin
      b_x = 3'(8 - k);
      b_y = 8'hB0 + 8'(k);
      step();
      chk_all($sformatf("cont B w%0d", k), (k == 4), (k < 4), 3'(8 - k), 8'hB0 + 8'(k), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
